// File: rtl/seq_det_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arbiter_ctrl_if
// Description : Bundle of requester handshake, result and detector signals
//               shared between seq_det_arbiter_ctrl and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_arbiter_ctrl_if #(
  parameter int W  = 16,
  parameter int CW = 5,
  parameter int PW = 4
);
  // requester side
  logic          req0;
  logic          req1;
  logic [W-1:0]  data0;
  logic [W-1:0]  data1;
  logic [1:0]    gnt;
  logic          busy;
  // result side
  logic          done;
  logic          done_id;
  logic [CW-1:0] count;
  logic          found;
  logic [PW-1:0] first_pos;
  // detector side
  logic          det_rst;
  logic          det_in;
  logic          det_op;

  // controller view
  modport master (
    input  req0, req1, data0, data1, det_op,
    output gnt, busy, done, done_id, count, found, first_pos, det_rst, det_in
  );

  // environment view (requesters plus detector)
  modport slave (
    output req0, req1, data0, data1, det_op,
    input  gnt, busy, done, done_id, count, found, first_pos, det_rst, det_in
  );
endinterface
`default_nettype wire

// File: rtl/seq_det_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_arbiter_ctrl
// Description : Round-robin sharing of one external 1010 Mealy detector
//               between two requesters; serializes a word MSB-first, counts
//               matches and reports count, first match position and ID.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_arbiter_ctrl #(
  parameter int W  = 16,
  parameter int CW = 5,
  parameter int PW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_det_arbiter_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_SHIFT  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [PW-1:0] LAST_IDX = PW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_acc_q, cnt_acc_d;
  logic [PW-1:0] pos_acc_q, pos_acc_d;
  logic          id_q, id_d;
  logic          last_q, last_d;
  logic [CW-1:0] count_q, count_d;
  logic          found_q, found_d;
  logic [PW-1:0] first_pos_q, first_pos_d;
  logic          done_id_q, done_id_d;
  logic [1:0]    gnt_w;
  logic          pick_w;

  // State, datapath and result registers; reset discards any word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      cnt_acc_q   <= '0;
      pos_acc_q   <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      count_q     <= '0;
      found_q     <= 1'b0;
      first_pos_q <= '0;
      done_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      cnt_acc_q   <= cnt_acc_d;
      pos_acc_q   <= pos_acc_d;
      id_q        <= id_d;
      last_q      <= last_d;
      count_q     <= count_d;
      found_q     <= found_d;
      first_pos_q <= first_pos_d;
      done_id_q   <= done_id_d;
    end
  end

  // Next-state logic: arbitration in IDLE, bit serialization and match
  // accumulation in SHIFT, result publication on the last bit
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    idx_d       = idx_q;
    cnt_acc_d   = cnt_acc_q;
    pos_acc_d   = pos_acc_q;
    id_d        = id_q;
    last_d      = last_q;
    count_d     = count_q;
    found_d     = found_q;
    first_pos_d = first_pos_q;
    done_id_d   = done_id_q;
    gnt_w       = 2'b00;
    pick_w      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst_n gates the grant so it cannot appear while reset is held
        if (rst_n && (bus.req0 || bus.req1)) begin
          // on a tie the requester that did not win last time goes first
          pick_w    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          gnt_w     = pick_w ? 2'b10 : 2'b01;
          sr_d      = pick_w ? bus.data1 : bus.data0;
          idx_d     = '0;
          cnt_acc_d = '0;
          pos_acc_d = '0;
          id_d      = pick_w;
          last_d    = pick_w;
          state_d   = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.det_op) begin
          if (cnt_acc_q == '0) begin
            pos_acc_d = idx_q;
          end
          if (cnt_acc_q != CNT_MAX) begin
            cnt_acc_d = cnt_acc_q + 1'b1;
          end
        end
        sr_d  = {sr_q[W-2:0], 1'b0};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // publish including the final bit's match so REPORT shows it
          count_d     = cnt_acc_d;
          found_d     = (cnt_acc_d != '0);
          first_pos_d = pos_acc_d;
          done_id_d   = id_q;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from state or come straight from registers
  assign bus.gnt       = gnt_w;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_REPORT);
  assign bus.det_rst   = (state_q == S_SHIFT);
  assign bus.det_in    = (state_q == S_SHIFT) && sr_q[W-1];
  assign bus.count     = count_q;
  assign bus.found     = found_q;
  assign bus.first_pos = first_pos_q;
  assign bus.done_id   = done_id_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_arbiter_ctrl
// Description : Self-checking bench: behavioural 1010 detector, cycle-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_arbiter_ctrl;
  localparam int W  = 16;
  localparam int CW = 5;
  localparam int PW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cycle;

  seq_det_arbiter_ctrl_if #(.W(W), .CW(CW), .PW(PW)) bus ();

  seq_det_arbiter_ctrl #(.W(W), .CW(CW), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1010 non-overlapping Mealy detector (held in reset by det_rst low)
  logic [1:0] dst;
  assign bus.det_op = bus.det_rst && (dst == 2'd3) && !bus.det_in;
  always @(posedge clk) begin
    if (!bus.det_rst) dst <= 2'd0;
    else begin
      case (dst)
        2'd0: dst <= bus.det_in ? 2'd1 : 2'd0;
        2'd1: dst <= bus.det_in ? 2'd1 : 2'd2;
        2'd2: dst <= bus.det_in ? 2'd3 : 2'd0;
        default: dst <= bus.det_in ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Reference: scan the word as a bit string for non-overlapping 1010 occurrences
  function automatic void ref_scan(input logic [W-1:0] w, output int cnt, output int pos);
    int i;
    cnt = 0; pos = 0; i = 0;
    while (i <= W - 4) begin
      if (w[W-1-i] && !w[W-2-i] && w[W-3-i] && !w[W-4-i]) begin
        if (cnt == 0) pos = i + 3;
        if (cnt < (1 << CW) - 1) cnt++;
        i += 4;
      end else begin
        i++;
      end
    end
  endfunction

  // Reference model: p = cycles since grant (0 idle, 1 clear, 2..W+1 bits, W+2 report)
  int          p;
  logic        m_last;
  logic        m_id;
  logic [W-1:0] m_word;
  logic [1:0]  m_gnt_q;
  logic        m_pick;
  int          e_cnt, e_pos;
  logic        e_id;
  logic [1:0]  x_gnt;
  logic        x_det_in;

  always @(negedge clk) begin
    if (!rst_n) begin
      p = 0; m_last = 1'b1; m_gnt_q = 2'b00;
      e_cnt = 0; e_pos = 0; e_id = 1'b0;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_det_rst", bus.det_rst, 0);
      chk("rst_det_in", bus.det_in, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_found", bus.found, 0);
      chk("rst_first_pos", bus.first_pos, 0);
      chk("rst_done_id", bus.done_id, 0);
    end else begin
      x_gnt = 2'b00; m_pick = 1'b0;
      if (p == 0 && (bus.req0 || bus.req1)) begin
        m_pick = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        x_gnt  = m_pick ? 2'b10 : 2'b01;
      end
      x_det_in = (p >= 2 && p <= W + 1) ? m_word[W + 1 - p] : 1'b0;
      if (p == W + 2) begin
        ref_scan(m_word, e_cnt, e_pos);
        e_id = m_id;
      end
      chk("gnt", bus.gnt, x_gnt);
      chk("busy", bus.busy, p != 0);
      chk("done", bus.done, p == W + 2);
      chk("det_rst", bus.det_rst, (p >= 2 && p <= W + 1));
      chk("det_in", bus.det_in, x_det_in);
      chk("count", bus.count, e_cnt);
      chk("found", bus.found, e_cnt != 0);
      chk("first_pos", bus.first_pos, e_pos);
      chk("done_id", bus.done_id, e_id);
      m_gnt_q = x_gnt;
      if (x_gnt != 2'b00) begin
        m_word = m_pick ? bus.data1 : bus.data0;
        m_id = m_pick; m_last = m_pick; p = 1;
      end else if (p == W + 2) p = 0;
      else if (p != 0) p++;
    end
  end

  // Advance one cycle; requests drop once the model says they were granted
  task automatic tick();
    @(posedge clk); #1;
    if (m_gnt_q[0]) bus.req0 = 1'b0;
    if (m_gnt_q[1]) bus.req1 = 1'b0;
    cycle++;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin tick(); n++; end while (!bus.done && n < 60);
    if (!bus.done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (p != 0 && n < 60) begin tick(); n++; end
  endtask

  task automatic run_word(input string name, input logic id, input logic [W-1:0] d,
                          input int ec, input int ep);
    int t0;
    wait_idle();
    if (id) begin bus.data1 = d; bus.req1 = 1'b1; end
    else    begin bus.data0 = d; bus.req0 = 1'b1; end
    t0 = cycle;
    wait_done(name);
    chk({name, "_latency"}, cycle - t0, W + 2);
    chk({name, "_count"}, bus.count, ec);
    chk({name, "_first_pos"}, bus.first_pos, ep);
    chk({name, "_found"}, bus.found, ec != 0);
    chk({name, "_done_id"}, bus.done_id, id);
  endtask

  initial begin
    int c, q, t0;
    n_checks = 0; n_fail = 0; cycle = 0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = '0; bus.data1 = '0;

    // pin the reference scan with hand-derived values
    ref_scan(16'hAAAA, c, q); chk("pin_aaaa", c * 16 + q, 4 * 16 + 3);
    ref_scan(16'h5555, c, q); chk("pin_5555", c * 16 + q, 3 * 16 + 4);
    ref_scan(16'hA800, c, q); chk("pin_a800", c * 16 + q, 1 * 16 + 3);

    // both requesters high out of reset
    bus.data0 = 16'hA000; bus.data1 = 16'h5555;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1; #1;
    chk("arb_first_gnt", bus.gnt, 2'b01);
    wait_done("arb_a");
    chk("arb_a_id", bus.done_id, 0);
    chk("arb_a_count", bus.count, 1);
    chk("arb_a_pos", bus.first_pos, 3);
    tick(); #1;
    chk("arb_second_gnt", bus.gnt, 2'b10);
    wait_done("arb_b");
    chk("arb_b_id", bus.done_id, 1);
    chk("arb_b_count", bus.count, 3);
    chk("arb_b_pos", bus.first_pos, 4);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick(); #1;
    chk("arb_rereq_gnt", bus.gnt, 2'b01);
    wait_done("arb_c");
    wait_done("arb_d");
    chk("arb_d_id", bus.done_id, 1);

    // single word and pattern density
    run_word("single", 1'b0, 16'hA000, 1, 3);
    run_word("aaaa",   1'b0, 16'hAAAA, 4, 3);
    run_word("5555",   1'b1, 16'h5555, 3, 4);
    run_word("a800",   1'b0, 16'hA800, 1, 3);
    run_word("zero",   1'b1, 16'h0000, 0, 0);

    // cross-word isolation
    run_word("xw_a", 1'b0, 16'h0005, 0, 0);
    run_word("xw_b", 1'b1, 16'h0000, 0, 0);

    // reset during bit 7 of AAAA
    wait_idle();
    bus.data0 = 16'hAAAA; bus.req0 = 1'b1;
    c = 0;
    do begin tick(); c++; end while (p != 9 && c < 40);
    #1 rst_n = 1'b0; #1;
    chk("async_busy", bus.busy, 0);
    chk("async_det_rst", bus.det_rst, 0);
    chk("async_det_in", bus.det_in, 0);
    chk("async_count", bus.count, 0);
    chk("async_done", bus.done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_word("post_rst", 1'b0, 16'hAAAA, 4, 3);

    // request arriving while busy
    wait_idle();
    bus.data0 = 16'hA800; bus.req0 = 1'b1;
    t0 = cycle;
    repeat (3) tick();
    bus.data1 = 16'h5555; bus.req1 = 1'b1;
    wait_done("pend_a");
    chk("pend_a_count", bus.count, 1);
    tick(); #1;
    chk("pend_gnt", bus.gnt, 2'b10);
    chk("pend_gnt_cycle", cycle - t0, W + 3);
    wait_done("pend_b");
    chk("pend_b_count", bus.count, 3);
    chk("pend_b_id", bus.done_id, 1);

    // random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (!bus.req0 && ($urandom_range(0, 3) == 0)) begin
        bus.data0 = ($urandom_range(0, 3) == 0) ? 16'hAAAA : 16'($urandom);
        bus.req0 = 1'b1;
      end
      if (!bus.req1 && ($urandom_range(0, 3) == 0)) begin
        bus.data1 = 16'($urandom);
        bus.req1 = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
      end
      tick();
    end
    c = 0;
    while ((bus.req0 || bus.req1 || p != 0) && c < 200) begin tick(); c++; end
    chk("drain", (bus.req0 || bus.req1 || p != 0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_det_arbiter_ctrl.md
# seq_det_arbiter_ctrl

Controller that shares one external 1010 non-overlapping Mealy sequence detector between two requesters. A requester presents a W-bit word. The block arbitrates round-robin, clears the detector, and serializes the word MSB-first into the detector. It counts the detector's match pulses, then reports the count, the first match position and the requester ID with a one-cycle done pulse. It sits between two word producers and the detector instance.

## Interface
- W, 16: word width in bits; must be ≥ 4.
- CW, 5: Count width; must hold W/4.
- PW, 4: First_Pos width, ceil(log2(W)).
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-low reset.
- Req0, Req1  input  1  request from requester 0 / 1; held high until granted.
- Data0, Data1  input  W  word for requester 0 / 1; must be stable in the grant cycle.
- Gnt  output  2  one-hot grant, high for exactly one cycle; the word is captured at the end of that cycle.
- Busy  output  1  high in every state except IDLE.
- Det_Rst  output  1  active-low reset driven to the detector.
- Det_In  output  1  serial bit driven to the detector.
- Det_OP  input  1  detector match output; combinational from Det_In in the same cycle.
- Done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
- Done_Id  output  1  requester whose word produced the result.
- Count  output  CW  number of Det_OP pulses during the word, saturating at all-ones.
- Found  output  1  Count != 0.
- First_Pos  output  PW  bit index (0 = MSB, first bit sent) of the first Det_OP pulse; 0 when Found=0.

## Operation
- FSM states: IDLE, CLR, SHIFT, REPORT.
- IDLE:
  - Det_Rst=0, Det_In=0.
  - If any Req is high, grant a requester and assert Gnt combinationally.
  - Capture the granted Data into the shift register; set bit index to 0 and clear the Count, Found and position accumulators.
  - Record the granted ID, update Last, then go to CLR.
- Arbitration:
  - Only one Req high: that requester wins.
  - Both Req high: the requester other than Last wins.
  - Last resets to 1, so requester 0 wins the first tie after reset.
- CLR: one cycle with Det_Rst=0 and Det_In=0. This forces the detector to its initial state so no match spans two words. Go to SHIFT.
- SHIFT: W cycles.
  - Det_Rst=1; Det_In = shift-register MSB.
  - On each clock edge: if Det_OP=1, increment the Count accumulator (saturating). On the first such pulse, load the position accumulator with the bit index.
  - Shift left by 1 and increment the bit index.
  - After bit index W-1, go to REPORT.
- REPORT:
  - Det_Rst=0, Det_In=0.
  - Assert Done for one cycle and drive Count, Found, First_Pos and Done_Id from the accumulators.
  - The result outputs hold their values until the next REPORT.
  - Go to IDLE.
- Req pending while Busy=1 is not lost: it is evaluated in the next IDLE cycle. The block never grants outside IDLE.
- Det_OP is ignored outside SHIFT.
- Reset (asynchronous, at any time including mid-SHIFT):
  - FSM goes to IDLE and Last=1.
  - The shift register, bit index and accumulators clear.
  - Gnt=0, Done=0, Count=0, Found=0, First_Pos=0, Done_Id=0, Busy=0, Det_Rst=0, Det_In=0.
  - A word in flight is discarded with no Done.

## Timing
- Grant in cycle T (IDLE).
- CLR in cycle T+1.
- SHIFT in cycles T+2 … T+W+1; bit k is on Det_In in cycle T+2+k.
- Done in cycle T+W+2.
- Earliest next grant is cycle T+W+3. Throughput is one word per W+3 cycles under continuous requests.
- Gnt and Busy are combinational from state and Req in IDLE. All other outputs are registered or decoded from state only.
- Done, Gnt and Busy never glitch across reset release. The first grant is possible in the first IDLE cycle after Rst deasserts.

## Test plan
All scenarios use W=16 and a behavioural 1010 non-overlapping Mealy detector model connected to Det_Rst, Det_In and Det_OP.
- **Single word:** Req0 with Data0=16'hA000 → Gnt=2'b01 in cycle T, Done at T+18, Count=1, Found=1, First_Pos=3, Done_Id=0.
- **Pattern density:**
  - 16'hAAAA → Count=4, First_Pos=3.
  - 16'h5555 → Count=3, First_Pos=4.
  - 16'hA800 → Count=1; this proves non-overlap is preserved.
  - 16'h0000 → Count=0, Found=0, First_Pos=0.
- **Cross-word isolation:** Req0 Data0=16'h0005 (ends in the detector's 101 state), then Req1 Data1=16'h0000 → the second result is Count=0. Det_Rst is low in every CLR cycle.
- **Arbitration:**
  - Req0 and Req1 both high from reset release → Gnt 01, then Gnt 10; Done_Id 0 then 1; each Gnt is exactly one cycle.
  - Both requesters then re-request → next grant goes to 0.
  - Gnt is never asserted while Busy=1.
- **Reset mid-operation:** assert Rst during SHIFT bit 7 of 16'hAAAA → all outputs go to their reset values asynchronously and no Done appears. The next request completes normally with Count=4.
- **Pending request while busy:** Req1 rises at grant cycle +3 of a requester-0 transfer → Gnt=2'b10 in the first IDLE cycle after Done (T+19), with correct results for both words.
